riscv_regfile_2r1w: RTL and testbench
=====================================

Name: riscv_regfile_2r1w

Overview:
- Parametrised integer register file for the RV32 core, successor to the fixed 64x32 dual-port BSRAM register file.
- Two synchronous read ports (rs1/rs2) and one write port (rd), all on a single clock, with optional hardwired-zero x0 and write-to-read bypass.
- Runs a post-reset clear sequencer that zeroes every entry so the core sees defined register contents without BSRAM init values.
- Sits between decode (read addresses) and writeback (write port). Storage must map to inferred block RAM: one write port and two read copies.

Parameters:
- XLEN, 32, data width in bits.
- AW, 5, address width; depth NREG = 2**AW (AW=4 gives RV32E).
- ZERO_REG, 1, 1 = reads of address 0 return 0 and writes to address 0 are dropped.
- BYPASS, 1, 1 = same-cycle write forwarded to a matching read.
- CLEAR_ON_RESET, 1, 1 = run the clear sequencer after reset; 0 = skip it (busy never asserts).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rd_en  in  1  read enable; captures read addresses and updates both outputs.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data, registered.
- rs2_data  out  XLEN  read port 2 data, registered.
- we  in  1  write enable.
- rd_addr  in  AW  write address.
- rd_data  in  XLEN  write data.
- busy  out  1  clear sequence in progress; core must stall.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - rs1_data=0, rs2_data=0.
  - Clear index=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else to RUN.
  - busy=1 if CLEAR_ON_RESET=1, else busy=0.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Each cycle writes 0 to entry[index], then index increments.
  - Exits to RUN on the cycle that writes index NREG-1, so busy=1 for exactly NREG cycles after reset release.
  - External we is ignored (the write is lost).
  - rs1_data and rs2_data are held at 0 regardless of rd_en.
- RUN: never leaves except by reset.
- Reset asserted mid-CLEAR restarts the clear from index 0.
- Write (RUN):
  - If we=1, entry[rd_addr] <= rd_data at the clk edge.
  - When ZERO_REG=1 and rd_addr=0, the write is suppressed.
- Read (RUN):
  - If rd_en=1 at edge N, rs1_data/rs2_data show entry[rs1_addr]/entry[rs2_addr] after edge N (latency 1).
  - If rd_en=0, outputs hold their previous value.
- ZERO_REG=1: a read of address 0 returns 0 irrespective of storage contents.
- Bypass:
  - Applies when BYPASS=1, we=1, rd_en=1 and rs*_addr==rd_addr in the same cycle, excluding address 0 when ZERO_REG=1.
  - The matching output takes rd_data.
  - Each port is checked independently; both ports may bypass simultaneously.
  - With BYPASS=0 the matching output returns the old contents (read-before-write).
- Read-after-write one cycle later always returns the new data, whatever BYPASS is set to.
- Addresses are full width: no aliasing, no wrap. The clear index wraps to 0 after NREG-1 but CLEAR is left at that point.
- Write and read to different addresses in the same cycle have no interaction.

Test Plan:
- Reset, then release with AW=5 -> busy=1 for 32 cycles, then 0. A we=1, rd_addr=3, data=0xDEADBEEF during busy is lost, and reading x3 afterwards returns 0. All 32 entries read 0.
- In RUN: write x5=0x12345678, then next cycle rd_en=1, rs1=5, rs2=5 -> both outputs 0x12345678 after one edge. With rd_en=0 the following cycle, the outputs hold that value.
- Write x0=0xFFFFFFFF, then read rs1=0 -> 0. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
- Same-cycle we=1, rd_addr=7, data=0xA5A5A5A5, rs1=7, rs2=8, where x7 previously held 0x11 -> with BYPASS=1: rs1_data=0xA5A5A5A5, rs2_data=x8 contents. With BYPASS=0: rs1_data=0x11.
- Same-cycle bypass on both ports: rs1=rs2=rd_addr=9, data=0x0BADF00D -> both outputs 0x0BADF00D.
- Assert reset_n=0 for 1 cycle at clear index 10 -> busy remains 1 for a full 32 cycles from the new release, and rs1_data/rs2_data=0 throughout.

Source files
------------

// File: rtl/riscv_regfile_2r1w_if.sv
// Core-side bundle of the 2-read / 1-write integer register file.
// Master is the pipeline (decode + writeback); slave is the register file.
interface riscv_regfile_2r1w_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            rd_en;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            busy;

    modport master (
        output rd_en, rs1_addr, rs2_addr, we, rd_addr, rd_data,
        input  rs1_data, rs2_data, busy
    );

    modport slave (
        input  rd_en, rs1_addr, rs2_addr, we, rd_addr, rd_data,
        output rs1_data, rs2_data, busy
    );
endinterface

// File: rtl/riscv_regfile_2r1w.sv
// Integer register file: two registered read ports, one write port, optional x0
// hardwiring and write-to-read bypass, plus a post-reset clear sequencer.
module riscv_regfile_2r1w #(
    parameter int XLEN           = 32,
    parameter int AW             = 5,
    parameter bit ZERO_REG       = 1'b1,
    parameter bit BYPASS         = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    riscv_regfile_2r1w_if.slave   bus
);
    localparam int NREG = 2 ** AW;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state_q;
    logic            busy_q;
    logic [AW-1:0]   clr_idx_q;
    logic            run;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   raddr [2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            busy_q    <= CLEAR_ON_RESET;
            clr_idx_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
            if (clr_idx_q == {AW{1'b1}}) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b0;
            end
        end
    end

    assign run = (state_q == ST_RUN);

    // The clear sequencer owns the write port until RUN; external writes are dropped.
    assign wr_en   = reset_n && (!run || (bus.we && !(ZERO_REG && (bus.rd_addr == '0))));
    assign wr_addr = run ? bus.rd_addr : clr_idx_q;
    assign wr_data = run ? bus.rd_data : '0;

    assign raddr[0] = bus.rs1_addr;
    assign raddr[1] = bus.rs2_addr;

    // One full RAM copy per read port so each maps onto a simple dual-port block.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [XLEN-1:0] mem_q [NREG];
        logic [XLEN-1:0] rdata_q;
        logic            zero_hit;
        logic            byp_hit;

        assign zero_hit = ZERO_REG && (raddr[gi] == '0);
        assign byp_hit  = BYPASS && bus.we && bus.rd_en &&
                          (raddr[gi] == bus.rd_addr) && !zero_hit;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n || !run) begin
                rdata_q <= '0;
            end else if (bus.rd_en) begin
                if (zero_hit) begin
                    rdata_q <= '0;
                end else if (byp_hit) begin
                    rdata_q <= bus.rd_data;
                end else begin
                    rdata_q <= mem_q[raddr[gi]];
                end
            end
        end
    end

    assign bus.rs1_data = g_rd[0].rdata_q;
    assign bus.rs2_data = g_rd[1].rdata_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_riscv_regfile_2r1w.sv
// Directed bench for riscv_regfile_2r1w: three instances (default, ZERO_REG=0,
// BYPASS=0) share one stimulus stream and are checked against hand-built tables.
module tb_riscv_regfile_2r1w;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    riscv_regfile_2r1w_if #(.XLEN(32), .AW(5)) if_a ();
    riscv_regfile_2r1w_if #(.XLEN(32), .AW(5)) if_z ();
    riscv_regfile_2r1w_if #(.XLEN(32), .AW(5)) if_b ();

    riscv_regfile_2r1w #(.XLEN(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    riscv_regfile_2r1w #(.XLEN(32), .AW(5), .ZERO_REG(1'b0), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1))
        dut_z (.clk(clk), .reset_n(reset_n), .bus(if_z));
    riscv_regfile_2r1w #(.XLEN(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    assign if_z.rd_en    = if_a.rd_en;
    assign if_z.rs1_addr = if_a.rs1_addr;
    assign if_z.rs2_addr = if_a.rs2_addr;
    assign if_z.we       = if_a.we;
    assign if_z.rd_addr  = if_a.rd_addr;
    assign if_z.rd_data  = if_a.rd_data;
    assign if_b.rd_en    = if_a.rd_en;
    assign if_b.rs1_addr = if_a.rs1_addr;
    assign if_b.rs2_addr = if_a.rs2_addr;
    assign if_b.we       = if_a.we;
    assign if_b.rd_addr  = if_a.rd_addr;
    assign if_b.rd_data  = if_a.rd_data;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] a1, a2;   // default instance
        logic [31:0] z1, z2;   // ZERO_REG=0
        logic [31:0] b1, b2;   // BYPASS=0
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra1, input logic [4:0] ra2);
        if_a.we       = we;
        if_a.rd_addr  = wa;
        if_a.rd_data  = wd;
        if_a.rd_en    = re;
        if_a.rs1_addr = ra1;
        if_a.rs2_addr = ra2;
    endtask

    // Called at a negedge with reset just released; counts busy cycles and
    // checks both outputs of every instance stay at zero while busy.
    task automatic count_busy(input string tag);
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (if_a.busy) begin
                cnt++;
                check($sformatf("%s_rs1_busy_a", tag), if_a.rs1_data, 32'h0);
                check($sformatf("%s_rs2_busy_a", tag), if_a.rs2_data, 32'h0);
                check($sformatf("%s_rs1_busy_b", tag), if_b.rs1_data, 32'h0);
                tick();
            end else begin
                done = 1'b1;
            end
        end
        check($sformatf("%s_busy_cycles", tag), 32'(cnt), 32'd32);
        check($sformatf("%s_busy_z", tag), {31'h0, if_z.busy}, 32'h0);
        check($sformatf("%s_busy_b", tag), {31'h0, if_b.busy}, 32'h0);
        $display("%s: busy held for %0d cycles", tag, cnt);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,
                     32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b1, 5'd5,  32'h0000CAFE, 1'b0, 5'd1,  5'd2,
                     32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,
                     32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd5,
                     32'h0, 32'h0000CAFE, 32'hFFFFFFFF, 32'h0000CAFE, 32'h0, 32'h0000CAFE};
        vecs[5]  = '{1'b1, 5'd7,  32'h00000011, 1'b1, 5'd5,  5'd6,
                     32'h0000CAFE, 32'h0, 32'h0000CAFE, 32'h0, 32'h0000CAFE, 32'h0};
        vecs[6]  = '{1'b1, 5'd8,  32'h00000022, 1'b0, 5'd8,  5'd8,
                     32'h0000CAFE, 32'h0, 32'h0000CAFE, 32'h0, 32'h0000CAFE, 32'h0};
        vecs[7]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd8,
                     32'hA5A5A5A5, 32'h22, 32'hA5A5A5A5, 32'h22, 32'h11, 32'h22};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[9]  = '{1'b1, 5'd9,  32'h0BADF00D, 1'b1, 5'd9,  5'd9,
                     32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 5'd0,  32'h00000033, 1'b1, 5'd0,  5'd0,
                     32'h0, 32'h0, 32'h33, 32'h33, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd9,
                     32'h0, 32'h0BADF00D, 32'h33, 32'h0BADF00D, 32'h0, 32'h0BADF00D};
        vecs[12] = '{1'b1, 5'd31, 32'h5A5A0001, 1'b1, 5'd31, 5'd30,
                     32'h5A5A0001, 32'h0, 32'h5A5A0001, 32'h0, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd30, 5'd31,
                     32'h0, 32'h5A5A0001, 32'h0, 32'h5A5A0001, 32'h0, 32'h5A5A0001};

        // Reset state
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        repeat (3) tick();
        check("reset_rs1", if_a.rs1_data, 32'h0);
        check("reset_rs2", if_a.rs2_data, 32'h0);
        check("reset_busy", {31'h0, if_a.busy}, 32'h1);
        $display("reset: busy=%0d rs1=%h rs2=%h", if_a.busy, if_a.rs1_data, if_a.rs2_data);

        // Clear sequence with a write that must be lost and reads that must stay 0
        reset_n = 1'b1;
        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 5'd3);
        count_busy("clear");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
        tick();
        check("lost_write_x3_a", if_a.rs1_data, 32'h0);
        check("lost_write_x3_z", if_z.rs2_data, 32'h0);
        $display("read x3 after clear: %h", if_a.rs1_data);

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
            tick();
            check($sformatf("sweep_rs1_x%0d", i), if_z.rs1_data, 32'h0);
            check($sformatf("sweep_rs2_x%0d", 31 - i), if_z.rs2_data, 32'h0);
            $display("sweep x%0d/x%0d: %h %h", i, 31 - i, if_z.rs1_data, if_z.rs2_data);
        end

        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re, vecs[v].ra1, vecs[v].ra2);
            tick();
            check($sformatf("vec%0d_rs1_a", v), if_a.rs1_data, vecs[v].a1);
            check($sformatf("vec%0d_rs2_a", v), if_a.rs2_data, vecs[v].a2);
            check($sformatf("vec%0d_rs1_z", v), if_z.rs1_data, vecs[v].z1);
            check($sformatf("vec%0d_rs2_z", v), if_z.rs2_data, vecs[v].z2);
            check($sformatf("vec%0d_rs1_b", v), if_b.rs1_data, vecs[v].b1);
            check($sformatf("vec%0d_rs2_b", v), if_b.rs2_data, vecs[v].b2);
            $display("vec %0d: we=%0d rd=%0d wd=%h re=%0d rs1=%0d rs2=%0d -> a=%h/%h z=%h/%h b=%h/%h",
                     v, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re, vecs[v].ra1, vecs[v].ra2,
                     if_a.rs1_data, if_a.rs2_data, if_z.rs1_data, if_z.rs2_data,
                     if_b.rs1_data, if_b.rs2_data);
        end

        // Reset mid-clear at index 10 must restart a full clear
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        tick();
        check("reclear_reset_rs2", if_a.rs2_data, 32'h0);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("preclear_busy_%0d", c), {31'h0, if_a.busy}, 32'h1);
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_busy("reclear");
        tick();
        check("reclear_x5_rs1", if_a.rs1_data, 32'h0);
        check("reclear_x5_rs2_b", if_b.rs2_data, 32'h0);
        $display("read x5 after re-clear: %h", if_a.rs1_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
